// File: rtl/ysyx_22050019_wbu_if.sv
// Writeback unit bundle: enqueue, commit, register-file write, issue and hazard query.
// master drives the requests into the unit; slave is the writeback unit itself.
interface ysyx_22050019_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rf_wen;
    logic [DATA_WIDTH-1:0] in_wdata;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [DATA_WIDTH-1:0] commit_pc;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  iss_ready;

    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic                  busy1;
    logic                  busy2;

    modport master (
        output in_valid, in_pc, in_rd, in_rf_wen, in_wdata,
        output commit_ready, iss_valid, iss_rd, raddr1, raddr2,
        input  in_ready, commit_valid, commit_pc,
        input  rf_wen, rf_waddr, rf_wdata, iss_ready, busy1, busy2
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rf_wen, in_wdata,
        input  commit_ready, iss_valid, iss_rd, raddr1, raddr2,
        output in_ready, commit_valid, commit_pc,
        output rf_wen, rf_waddr, rf_wdata, iss_ready, busy1, busy2
    );
endinterface

// File: rtl/ysyx_22050019_wbu.sv
// Writeback unit: 2-entry in-order retirement FIFO driving the register file write port,
// plus a per-register pending-write scoreboard for decode hazard detection.
module ysyx_22050019_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                rst,
    ysyx_22050019_wbu_if.slave wb
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  rf_wen;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t      fifo_q [2];
    entry_t      head;
    logic        rptr;
    logic        wptr;
    logic [1:0]  count;
    logic        enq_fire;
    logic        commit_fire;

    logic [1:0]      cnt [NREG];
    logic            iss_fire;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    // No pass-through: a full FIFO refuses input even when the head retires this cycle.
    assign wb.in_ready     = (count != 2'd2);
    assign wb.commit_valid = (count != 2'd0);
    assign enq_fire        = wb.in_valid & wb.in_ready;
    assign commit_fire     = wb.commit_valid & wb.commit_ready;
    assign head            = fifo_q[rptr];

    assign wb.commit_pc = head.pc;
    assign wb.rf_wen    = commit_fire & head.rf_wen & (head.rd != '0);
    assign wb.rf_waddr  = head.rd;
    assign wb.rf_wdata  = head.wdata;

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            fifo_q[wptr] <= '{pc: wb.in_pc, rd: wb.in_rd, rf_wen: wb.in_rf_wen, wdata: wb.in_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= '0;
        end else begin
            if (enq_fire)    wptr <= ~wptr;
            if (commit_fire) rptr <= ~rptr;
            case ({enq_fire, commit_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign iss_fire     = wb.iss_valid & wb.iss_ready & (wb.iss_rd != '0);
    assign wb.iss_ready = (wb.iss_rd == '0) | (cnt[wb.iss_rd] != 2'd3);
    assign wb.busy1     = (wb.raddr1 != '0) & (cnt[wb.raddr1] != 2'd0);
    assign wb.busy2     = (wb.raddr2 != '0) & (cnt[wb.raddr2] != 2'd0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_fire)  inc_vec[wb.iss_rd]   = 1'b1;
        if (wb.rf_wen) dec_vec[wb.rf_waddr] = 1'b1;
    end

    // Entry 0 is never incremented, so x0 stays at zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i] && cnt[i] != 2'd0) begin
                    cnt[i] <= cnt[i] - 2'd1;
                end
            end
        end
    end

    // Retiring a write that was never issued means upstream broke the issue protocol.
    always_ff @(posedge clk) begin
        if (!rst && wb.rf_wen) begin
            assert (cnt[wb.rf_waddr] != 2'd0);
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_wbu.sv
// Scoreboard bench for ysyx_22050019_wbu: stimulus pushes expected retirements,
// a negedge monitor pops and compares them against the commit/register-file port.
module tb_ysyx_22050019_wbu;
    logic clk;
    logic rst;

    ysyx_22050019_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) wb ();

    ysyx_22050019_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    typedef struct {
        logic [63:0] pc;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   total   = 0;
    int   passed  = 0;
    int   commits = 0;
    logic mon_en  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic issue(input logic [4:0] rd);
        wb.iss_valid = 1'b1;
        wb.iss_rd    = rd;
        #1;
        chk("iss_ready_on_issue", wb.iss_ready, 1'b1);
        @(posedge clk); #1;
        wb.iss_valid = 1'b0;
    endtask

    task automatic enq(input logic [63:0] pc, input logic [4:0] rd, input logic wen, input logic [63:0] d);
        exp_t e;
        int   n;
        logic r;
        wb.in_valid  = 1'b1;
        wb.in_pc     = pc;
        wb.in_rd     = rd;
        wb.in_rf_wen = wen;
        wb.in_wdata  = d;
        n = 0;
        do begin
            #1;
            r = wb.in_ready;
            if (r) begin
                e.pc = pc; e.wen = wen && (rd != 5'd0); e.rd = rd; e.wdata = d;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end while (!r && n < 20);
        if (!r) begin
            total++;
            $display("FAIL enq_timeout: in_ready stayed %0b expected 1 (pc %0h)", r, pc);
        end
        wb.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb.commit_valid && wb.commit_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL commit_unexpected: got pc %0h expected no commit", wb.commit_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    commits++;
                    chk("commit_pc", wb.commit_pc, mon_e.pc);
                    chk("rf_wen", wb.rf_wen, mon_e.wen);
                    if (mon_e.wen) begin
                        chk("rf_waddr", wb.rf_waddr, mon_e.rd);
                        chk("rf_wdata", wb.rf_wdata, mon_e.wdata);
                    end
                end
            end else if (wb.rf_wen) begin
                total++;
                $display("FAIL rf_wen_no_commit: got rf_wen 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wb.in_valid = 1'b0; wb.in_pc = '0; wb.in_rd = '0; wb.in_rf_wen = 1'b0; wb.in_wdata = '0;
        wb.commit_ready = 1'b1;
        wb.iss_valid = 1'b0; wb.iss_rd = '0;
        wb.raddr1 = '0; wb.raddr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("reset_in_ready", wb.in_ready, 1'b1);
        chk("reset_commit_valid", wb.commit_valid, 1'b0);
        chk("reset_rf_wen", wb.rf_wen, 1'b0);
        chk("reset_iss_ready", wb.iss_ready, 1'b1);
        wb.raddr1 = 5'd5; wb.raddr2 = 5'd7;
        #1;
        chk("reset_busy1", wb.busy1, 1'b0);
        chk("reset_busy2", wb.busy2, 1'b0);

        // Single instruction: issue x5, enqueue next cycle, retire the cycle after.
        issue(5'd5);
        chk("single_busy_after_issue", wb.busy1, 1'b1);
        enq(64'h8000_0000, 5'd5, 1'b1, 64'hDEAD_BEEF);
        chk("single_commit_valid", wb.commit_valid, 1'b1);
        chk("single_busy_during_retire", wb.busy1, 1'b1);
        @(posedge clk); #1;
        chk("single_busy_cleared", wb.busy1, 1'b0);
        chk("single_fifo_empty", wb.commit_valid, 1'b0);

        // Back-pressure: two accepts fill the FIFO, the third waits for commits.
        wb.commit_ready = 1'b0;
        enq(64'h0, 5'd1, 1'b0, 64'h11);
        enq(64'h4, 5'd2, 1'b0, 64'h22);
        wb.in_valid = 1'b1; wb.in_pc = 64'h8; wb.in_rd = 5'd3; wb.in_rf_wen = 1'b0;
        #1;
        chk("bp_full_in_ready", wb.in_ready, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("bp_held_in_ready", wb.in_ready, 1'b0);
        chk("bp_head_stable_pc", wb.commit_pc, 64'h0);
        chk("bp_head_valid", wb.commit_valid, 1'b1);
        wb.in_valid = 1'b0;
        wb.commit_ready = 1'b1;
        enq(64'h8, 5'd3, 1'b0, 64'h33);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_drained", wb.commit_valid, 1'b0);

        // x0 write is suppressed and never tracked.
        wb.raddr1 = 5'd0;
        wb.iss_rd = 5'd0;
        enq(64'h10, 5'd0, 1'b1, 64'h5555);
        @(posedge clk); #1;
        chk("x0_busy", wb.busy1, 1'b0);
        chk("x0_iss_ready", wb.iss_ready, 1'b1);

        // Scoreboard overlap and saturation on x7 (observed through raddr2 / iss_ready).
        issue(5'd7);
        issue(5'd7);
        enq(64'h20, 5'd7, 1'b1, 64'h7070);
        issue(5'd7);
        wb.iss_rd = 5'd7;
        #1;
        chk("overlap_not_saturated", wb.iss_ready, 1'b1);
        issue(5'd7);
        wb.iss_rd = 5'd7;
        #1;
        chk("saturated_iss_ready", wb.iss_ready, 1'b0);
        chk("saturated_busy2", wb.busy2, 1'b1);
        enq(64'h24, 5'd7, 1'b1, 64'h7171);
        enq(64'h28, 5'd7, 1'b1, 64'h7272);
        enq(64'h2C, 5'd7, 1'b1, 64'h7373);
        chk("two_retired_iss_ready", wb.iss_ready, 1'b1);
        chk("two_retired_busy2", wb.busy2, 1'b1);
        @(posedge clk); #1;
        chk("three_retired_busy2", wb.busy2, 1'b0);

        // Mid-operation reset discards queued entries and pending counts.
        wb.commit_ready = 1'b0;
        wb.raddr1 = 5'd3;
        issue(5'd3);
        issue(5'd3);
        enq(64'h100, 5'd3, 1'b1, 64'hAAAA);
        enq(64'h104, 5'd3, 1'b1, 64'hBBBB);
        chk("pre_reset_full", wb.in_ready, 1'b0);
        chk("pre_reset_busy", wb.busy1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_commit_valid", wb.commit_valid, 1'b0);
        chk("midrst_busy", wb.busy1, 1'b0);
        chk("midrst_in_ready", wb.in_ready, 1'b1);
        wb.commit_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        chk("queue_drained", exp_q.size(), 0);
        chk("commit_count", commits, 9);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
